// File: rtl/left_logic_shifter_pkg.sv
// Shared ALU constants used by the shift and logic units.
package left_logic_shifter_pkg;

  // Default ALU datapath width. ALU integration also uses it as the shifter width.
  localparam int ALU_WIDTH = 4;

endpackage : left_logic_shifter_pkg

// File: rtl/left_logic_shifter_if.sv
// Operand/result bundle for the shift-left-logical unit.
// The shifter keeps plain positional ports (a, clk, y, rst_n) because existing
// instantiations depend on that order. This interface groups the same two
// signals for the benches and the ALU glue that drive and observe the unit.
interface left_logic_shifter_if
  import left_logic_shifter_pkg::*;
#(
  parameter int N = ALU_WIDTH
);

  logic [N-1:0] a;
  logic [N-1:0] y;

  // The master drives the operand and observes the result.
  modport master (output a, input y);

  // The slave is the shifter side.
  modport slave (input a, output y);

endinterface : left_logic_shifter_if

// File: rtl/left_logic_shifter.sv
// Registered logical shift left by one bit.
// The MSB of a is dropped, a zero enters at the LSB, and the result is
// registered. There is no combinational path from a to y.
module left_logic_shifter
  import left_logic_shifter_pkg::*;
#(
  parameter int N = ALU_WIDTH
) (
  input  logic [N-1:0] a,
  input  logic         clk,
  output logic [N-1:0] y,
  input  logic         rst_n
);

  // Capture a << 1 on each rising edge. An asynchronous reset clears y at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= {a[N-2:0], 1'b0};
    end
  end

endmodule : left_logic_shifter

// File: tb/tb_left_logic_shifter.sv
// Self-checking bench for left_logic_shifter at N=4 and N=8.
module tb_left_logic_shifter;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  left_logic_shifter_if #(.N(4)) bus4 ();
  left_logic_shifter_if #(.N(8)) bus8 ();

  left_logic_shifter #(.N(4)) dut4 (
    .a     (bus4.a),
    .clk   (clk),
    .y     (bus4.y),
    .rst_n (rst_n)
  );

  left_logic_shifter #(.N(8)) dut8 (
    .a     (bus8.a),
    .clk   (clk),
    .y     (bus8.y),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: doubling the value and keeping the low w bits.
  function automatic logic [31:0] ref_shl(input logic [31:0] v, input int w);
    longint unsigned m;
    m = 64'd1 << w;
    return 32'((longint'(v) * 2) % m);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive both operands between edges, let one edge capture them, then check both results.
  task automatic apply(input string tag, input logic [3:0] v4, input logic [7:0] v8);
    @(negedge clk);
    bus4.a = v4;
    bus8.a = v8;
    @(posedge clk);
    #1;
    check({tag, "_n4"}, 32'(bus4.y), ref_shl(32'(v4), 4));
    check({tag, "_n8"}, 32'(bus8.y), ref_shl(32'(v8), 8));
  endtask

  initial begin
    logic [3:0] walk [5];
    logic [3:0] r4;
    logic [7:0] r8;
    logic [3:0] y_before;

    n_checks = 0;
    n_errors = 0;

    // Reset held across several edges while a is all ones.
    rst_n  = 1'b0;
    bus4.a = 4'b1111;
    bus8.a = 8'hFF;
    #1;
    check("reset_t0_n4", 32'(bus4.y), 32'h0);
    check("reset_t0_n8", 32'(bus8.y), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_n4", 32'(bus4.y), 32'h0);
      check("reset_hold_n8", 32'(bus8.y), 32'h0);
    end

    // Release reset between edges. Nothing is captured until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 32'(bus4.y), 32'h0);
    @(posedge clk);
    #1;
    check("release_first", 32'(bus4.y), 32'b1110);
    check("release_first_n8", 32'(bus8.y), 32'hFE);

    // Walking one through the 4-bit unit.
    walk[0] = 4'b0000;
    walk[1] = 4'b0001;
    walk[2] = 4'b0010;
    walk[3] = 4'b0100;
    walk[4] = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      apply("walk", walk[i], {walk[i], walk[i]});
    end
    check("walk_msb_drop", 32'(bus4.y), 32'h0);

    // The operand changes twice mid-cycle. y must hold until the next edge.
    @(negedge clk);
    y_before = bus4.y;
    bus4.a = 4'b0011;
    #1;
    check("hold_a1", 32'(bus4.y), 32'(y_before));
    #2;
    bus4.a = 4'b0101;
    #1;
    check("hold_a2", 32'(bus4.y), 32'(y_before));
    @(posedge clk);
    #1;
    check("hold_capture", 32'(bus4.y), 32'b1010);

    // All ones, alternating patterns and the 8-bit boundary values.
    apply("ones", 4'b1111, 8'h81);
    check("ones_lit", 32'(bus4.y), 32'b1110);
    check("n8_81_lit", 32'(bus8.y), 32'h02);
    apply("alt5", 4'b0101, 8'h7F);
    check("alt5_lit", 32'(bus4.y), 32'b1010);
    check("n8_7f_lit", 32'(bus8.y), 32'hFE);
    apply("altA", 4'b1010, 8'h80);
    check("altA_lit", 32'(bus4.y), 32'b0100);

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      r4 = 4'($urandom_range(0, 15));
      r8 = 8'($urandom_range(0, 255));
      apply("rand", r4, r8);
    end

    // Asynchronous reset mid-cycle while y holds 1000.
    apply("pre_async", 4'b0100, 8'h40);
    check("pre_async_lit", 32'(bus4.y), 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_n4", 32'(bus4.y), 32'h0);
    check("async_clear_n8", 32'(bus8.y), 32'h0);
    bus4.a = 4'b0111;
    bus8.a = 8'h33;
    @(posedge clk);
    #1;
    check("async_hold", 32'(bus4.y), 32'h0);

    // Release reset and change a just after an edge. The first capture is at the following edge.
    rst_n  = 1'b1;
    bus4.a = 4'b0011;
    bus8.a = 8'hC3;
    #1;
    check("rel2_no_edge", 32'(bus4.y), 32'h0);
    @(posedge clk);
    #1;
    check("rel2_first_n4", 32'(bus4.y), 32'b0110);
    check("rel2_first_n8", 32'(bus8.y), 32'h86);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound on total runtime.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_left_logic_shifter
